// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, horizontal state encoding and error-flag
// bit positions for the VGA sync monitor.
package vga_timing_pkg;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;
  localparam int DEF_LOCK_FRAMES = 2;

  localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  typedef logic [2:0] h_state_t;
  localparam h_state_t HS_UNKNOWN = 3'd0;
  localparam h_state_t HS_SYNC    = 3'd1;
  localparam h_state_t HS_BACK    = 3'd2;
  localparam h_state_t HS_VIS     = 3'd3;
  localparam h_state_t HS_FRONT   = 3'd4;

  localparam int ERR_HSYNC  = 0;
  localparam int ERR_HBACK  = 1;
  localparam int ERR_HVIS   = 2;
  localparam int ERR_HFRONT = 3;
  localparam int ERR_VSYNC  = 4;
  localparam int ERR_VTOTAL = 5;

  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/vga_hline_meter.sv
// Horizontal segment tracker: walks sync/back/visible/front per line, measures
// each segment and strobes width errors; also detects loss of hSync.
module vga_hline_meter
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hs_rise,
  input  logic        hs_fall,
  input  logic        vis_rise,
  input  logic        vis_fall,
  output logic [3:0]  h_err,
  output logic        timeout,
  output logic [10:0] meas_h_total
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam logic [10:0] SYNC_L    = 11'(H_SYNC);
  localparam logic [10:0] BACK_L    = 11'(H_BACK);
  localparam logic [10:0] VIS_L     = 11'(H_VISIBLE);
  localparam logic [10:0] FRONT_L   = 11'(H_FRONT);
  localparam logic [10:0] TOTAL_L   = 11'(H_TOTAL);
  localparam logic [10:0] TIMEOUT_L = 11'(2 * H_TOTAL);

  h_state_t    state_q, state_d;
  logic [10:0] seg_q, seg_d;
  logic [10:0] line_q, line_d;
  logic [10:0] meas_q, meas_d;
  logic        seen_q, seen_d;

  assign timeout      = (line_q == TIMEOUT_L) && !hs_rise;
  assign meas_h_total = meas_q;

  always_comb begin
    state_d = state_q;
    seg_d   = sat_inc11(seg_q);
    h_err   = 4'b0000;
    case (state_q)
      HS_SYNC: begin
        if (hs_fall) begin
          h_err[ERR_HSYNC] = (seg_q != SYNC_L);
          state_d = HS_BACK;
          seg_d   = 11'd1;
        end else if (vis_rise || vis_fall) begin
          h_err[ERR_HSYNC] = 1'b1;
          state_d = HS_UNKNOWN;
        end
      end
      HS_BACK: begin
        // A rise straight out of the back porch is a vertical-blanking line:
        // only the line length can be judged there.
        if (vis_rise) begin
          h_err[ERR_HBACK] = (seg_q != BACK_L);
          state_d = HS_VIS;
          seg_d   = 11'd1;
        end else if (hs_rise) begin
          h_err[ERR_HFRONT] = (line_q != TOTAL_L);
        end else if (vis_fall || hs_fall) begin
          h_err[ERR_HBACK] = 1'b1;
          state_d = HS_UNKNOWN;
        end
      end
      HS_VIS: begin
        if (vis_fall) begin
          h_err[ERR_HVIS] = (seg_q != VIS_L);
          state_d = HS_FRONT;
          seg_d   = 11'd1;
        end else if (vis_rise || hs_fall || hs_rise) begin
          h_err[ERR_HVIS] = 1'b1;
          state_d = HS_UNKNOWN;
        end
      end
      HS_FRONT: begin
        if (hs_rise) begin
          h_err[ERR_HFRONT] = (seg_q != FRONT_L) || (line_q != TOTAL_L);
        end else if (vis_rise || vis_fall || hs_fall) begin
          h_err[ERR_HFRONT] = 1'b1;
          state_d = HS_UNKNOWN;
        end
      end
      default: ;
    endcase
    // Visible ending on the very clock hSync rises means a zero-length front porch.
    if (hs_rise) begin
      if (state_q == HS_VIS && vis_fall) h_err[ERR_HFRONT] = 1'b1;
      state_d = HS_SYNC;
      seg_d   = 11'd1;
    end
    if (timeout) state_d = HS_UNKNOWN;
    line_d = hs_rise ? 11'd1 : sat_inc11(line_q);
    meas_d = (hs_rise && seen_q) ? line_q : meas_q;
    seen_d = seen_q | hs_rise;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HS_UNKNOWN;
      seg_q   <= 11'd0;
      line_q  <= 11'd0;
      meas_q  <= 11'd0;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      seg_q   <= seg_d;
      line_q  <= line_d;
      meas_q  <= meas_d;
      seen_q  <= seen_d;
    end
  end

endmodule

// File: rtl/vga_sync_monitor.sv
// Loop-back VGA timing checker: measures the incoming sync stream, declares lock
// after clean frames and recovers pixel coordinates.
module vga_sync_monitor
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE   = DEF_H_VISIBLE,
  parameter int H_FRONT     = DEF_H_FRONT,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BACK      = DEF_H_BACK,
  parameter int V_VISIBLE   = DEF_V_VISIBLE,
  parameter int V_FRONT     = DEF_V_FRONT,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BACK      = DEF_V_BACK,
  parameter int LOCK_FRAMES = DEF_LOCK_FRAMES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hSync,
  input  logic        vSync,
  input  logic        visible,
  output logic        locked,
  output logic        frameErr,
  output logic [5:0]  errFlags,
  output logic [10:0] measHTotal,
  output logic [10:0] measVTotal,
  output logic [9:0]  xOut,
  output logic [9:0]  yOut,
  output logic        pixValid,
  output logic [10:0] frames
);

  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [10:0] V_TOTAL_L = 11'(V_TOTAL);
  localparam logic [10:0] V_SYNC_L  = 11'(V_SYNC);
  localparam logic [10:0] V_VIS_L   = 11'(V_VISIBLE);
  localparam logic [10:0] LOCK_L    = 11'(LOCK_FRAMES);

  logic hs_q, vs_q, vis_q, hs_prev_q, vis_prev_q;
  logic hs_rise, hs_fall, vis_rise, vis_fall, boundary;
  logic [3:0] h_err;
  logic timeout;

  logic        line_vs_q, line_vs_d, line_vis_q, line_vis_d, line_vis_now;
  logic [10:0] v_lines_q, v_lines_d, v_sync_q, v_sync_d, v_vis_q, v_vis_d, vis_lines;
  logic [9:0]  y_cnt_q, y_cnt_d, x_cnt_q, x_cnt_d;
  logic [5:0]  sticky_q, sticky_d, flags;
  logic [1:0]  v_err;
  logic        armed_q, armed_d, locked_q, locked_d, frame_err_q, frame_err_d;
  logic [10:0] run_q, run_d, run_inc;
  logic [5:0]  err_flags_q, err_flags_d;
  logic [10:0] meas_v_q, meas_v_d, frames_q, frames_d;
  logic [9:0]  x_out_q, x_out_d, y_out_q, y_out_d;
  logic        pix_valid_q, pix_valid_d;

  assign hs_rise  = hs_q & ~hs_prev_q;
  assign hs_fall  = ~hs_q & hs_prev_q;
  assign vis_rise = vis_q & ~vis_prev_q;
  assign vis_fall = ~vis_q & vis_prev_q;
  assign boundary = hs_rise & vs_q & ~line_vs_q;

  vga_hline_meter #(
    .H_VISIBLE(H_VISIBLE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK)
  ) u_hline (
    .clk(clk), .reset(reset),
    .hs_rise(hs_rise), .hs_fall(hs_fall), .vis_rise(vis_rise), .vis_fall(vis_fall),
    .h_err(h_err), .timeout(timeout), .meas_h_total(measHTotal)
  );

  always_comb begin
    line_vs_d    = line_vs_q;
    line_vis_now = line_vis_q | vis_q;
    line_vis_d   = line_vis_now;
    v_lines_d    = v_lines_q;
    v_sync_d     = v_sync_q;
    v_vis_d      = v_vis_q;
    vis_lines    = line_vis_now ? sat_inc11(v_vis_q) : v_vis_q;
    y_cnt_d      = y_cnt_q;
    sticky_d     = sticky_q | {2'b00, h_err};
    v_err        = 2'b00;
    flags        = 6'b0;
    armed_d      = armed_q;
    run_inc      = (run_q >= LOCK_L) ? LOCK_L : run_q + 11'd1;
    run_d        = run_q;
    locked_d     = locked_q;
    frame_err_d  = 1'b0;
    err_flags_d  = err_flags_q;
    meas_v_d     = meas_v_q;
    frames_d     = frames_q;
    if (hs_rise) begin
      line_vs_d  = vs_q;
      line_vis_d = 1'b0;
      if (boundary) begin
        v_err[0] = (v_sync_q != V_SYNC_L);
        v_err[1] = (v_lines_q != V_TOTAL_L) || (vis_lines != V_VIS_L);
        flags    = sticky_q | {v_err, h_err};
        sticky_d = 6'b0;
        // An unarmed boundary only opens the first measured frame.
        if (armed_q) begin
          err_flags_d = flags;
          meas_v_d    = v_lines_q;
          if (|flags) begin
            frame_err_d = 1'b1;
            run_d       = 11'd0;
            locked_d    = 1'b0;
          end else begin
            run_d = run_inc;
            if (run_inc == LOCK_L) locked_d = 1'b1;
            if (locked_q) frames_d = frames_q + 11'd1;
          end
        end
        armed_d   = 1'b1;
        v_lines_d = 11'd1;
        v_sync_d  = 11'd1;
        v_vis_d   = 11'd0;
        y_cnt_d   = 10'd0;
      end else begin
        v_lines_d = sat_inc11(v_lines_q);
        v_sync_d  = vs_q ? sat_inc11(v_sync_q) : v_sync_q;
        v_vis_d   = vis_lines;
        y_cnt_d   = line_vis_now ? sat_inc10(y_cnt_q) : y_cnt_q;
      end
    end
    if (timeout) begin
      locked_d = 1'b0;
      run_d    = 11'd0;
      armed_d  = 1'b0;
    end
    if (vis_q) begin
      x_out_d = x_cnt_q;
      x_cnt_d = sat_inc10(x_cnt_q);
    end else begin
      x_out_d = 10'd0;
      x_cnt_d = 10'd0;
    end
    y_out_d     = y_cnt_q;
    pix_valid_d = locked_q & vis_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_q <= 1'b0; vs_q <= 1'b0; vis_q <= 1'b0;
      hs_prev_q <= 1'b0; vis_prev_q <= 1'b0;
      line_vs_q <= 1'b0; line_vis_q <= 1'b0;
      v_lines_q <= 11'd0; v_sync_q <= 11'd0; v_vis_q <= 11'd0;
      y_cnt_q <= 10'd0; x_cnt_q <= 10'd0;
      sticky_q <= 6'b0; armed_q <= 1'b0; run_q <= 11'd0;
      locked_q <= 1'b0; frame_err_q <= 1'b0; err_flags_q <= 6'b0;
      meas_v_q <= 11'd0; frames_q <= 11'd0;
      x_out_q <= 10'd0; y_out_q <= 10'd0; pix_valid_q <= 1'b0;
    end else begin
      hs_q <= hSync; vs_q <= vSync; vis_q <= visible;
      hs_prev_q <= hs_q; vis_prev_q <= vis_q;
      line_vs_q <= line_vs_d; line_vis_q <= line_vis_d;
      v_lines_q <= v_lines_d; v_sync_q <= v_sync_d; v_vis_q <= v_vis_d;
      y_cnt_q <= y_cnt_d; x_cnt_q <= x_cnt_d;
      sticky_q <= sticky_d; armed_q <= armed_d; run_q <= run_d;
      locked_q <= locked_d; frame_err_q <= frame_err_d; err_flags_q <= err_flags_d;
      meas_v_q <= meas_v_d; frames_q <= frames_d;
      x_out_q <= x_out_d; y_out_q <= y_out_d; pix_valid_q <= pix_valid_d;
    end
  end

  assign locked     = locked_q;
  assign frameErr   = frame_err_q;
  assign errFlags   = err_flags_q;
  assign measVTotal = meas_v_q;
  assign xOut       = x_out_q;
  assign yOut       = y_out_q;
  assign pixValid   = pix_valid_q;
  assign frames     = frames_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Frame-level bench for vga_sync_monitor using a shrunken timing (15x9) so that
// lock, error, timeout and reset scenarios fit in a few thousand clocks.
module tb_vga_sync_monitor;

  localparam int HV = 8, HF = 2, HS = 3, HB = 2;
  localparam int VV = 4, VF = 1, VS = 2, VB = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;

  localparam int K_NORM = 0, K_STRETCH = 1, K_DROP = 2, K_TIMEOUT = 3, K_RESET = 4;
  localparam int NROWS = 22;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hSync = 1'b0, vSync = 1'b0, visible = 1'b0;
  logic        locked, frameErr, pixValid;
  logic [5:0]  errFlags;
  logic [10:0] measHTotal, measVTotal, frames;
  logic [9:0]  xOut, yOut;

  int n_tests = 0;
  int n_fail  = 0;
  int n_ferr  = 0;
  int exp_x   = 0;
  int exp_y   = 0;
  bit pv_prev = 1'b0;

  typedef struct {
    int kind;
    int locked;
    int ferr;
    int flags;
    int measv;
    int frames;
  } row_t;
  row_t rows [NROWS];

  always #5 clk = ~clk;

  vga_sync_monitor #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .reset(reset), .hSync(hSync), .vSync(vSync), .visible(visible),
    .locked(locked), .frameErr(frameErr), .errFlags(errFlags),
    .measHTotal(measHTotal), .measVTotal(measVTotal),
    .xOut(xOut), .yOut(yOut), .pixValid(pixValid), .frames(frames)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_frameErr"}, frameErr, 0);
    chk({tag, "_errFlags"}, errFlags, 0);
    chk({tag, "_measH"}, measHTotal, 0);
    chk({tag, "_measV"}, measVTotal, 0);
    chk({tag, "_xOut"}, xOut, 0);
    chk({tag, "_yOut"}, yOut, 0);
    chk({tag, "_pixValid"}, pixValid, 0);
    chk({tag, "_frames"}, frames, 0);
  endtask

  // One generator line; hs_len stretches sync, no_hs suppresses it, rst_h pulses reset.
  task automatic send_line(input int v, input int hs_len, input bit no_hs, input int rst_h);
    bit rst_chk = 1'b0;
    for (int h = 0; h < HT; h++) begin
      @(posedge clk); #2;
      visible = (h < HV) && (v < VV);
      hSync   = !no_hs && (h >= HV + HF) && (h < HV + HF + hs_len);
      vSync   = (v >= VV + VF) && (v < VV + VF + VS);
      reset   = (h == rst_h);
      if (rst_chk) begin
        @(negedge clk);
        chk_zero("midreset");
        rst_chk = 1'b0;
      end
      if (h == rst_h) rst_chk = 1'b1;
    end
  endtask

  task automatic send_frame(input int kind);
    for (int v = 0; v < VT; v++) begin
      if (kind == K_DROP && v == 7) continue;
      send_line(v, (kind == K_STRETCH && v == 7) ? HS + 1 : HS,
                (kind == K_TIMEOUT && v >= 6), (kind == K_RESET && v == 2) ? 3 : -1);
    end
  endtask

  // Continuous pixel-stream and lock/error consistency monitor.
  always @(negedge clk) begin
    if (reset) begin
      exp_x   = 0;
      exp_y   = 0;
      pv_prev = 1'b0;
    end else begin
      if (pixValid) begin
        chk("xOut", xOut, exp_x);
        chk("yOut", yOut, exp_y);
        exp_x++;
      end else begin
        if (pv_prev) begin
          chk("pix_run", exp_x, HV);
          exp_x = 0;
          exp_y = (exp_y + 1) % VV;
        end
        if (locked) chk("xOut_idle", xOut, 0);
      end
      if (frameErr) begin
        n_ferr++;
        chk("lock_drop", locked, 0);
      end
      pv_prev = pixValid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ferr0;
    rows[0]  = '{K_NORM,    0, 0, 0,    0, 0};
    rows[1]  = '{K_NORM,    0, 0, 0,    9, 0};
    rows[2]  = '{K_NORM,    1, 0, 0,    9, 0};
    rows[3]  = '{K_NORM,    1, 0, 0,    9, 1};
    rows[4]  = '{K_STRETCH, 1, 0, 0,    9, 2};
    rows[5]  = '{K_NORM,    0, 1, 6'h01, 9, 2};
    rows[6]  = '{K_NORM,    0, 0, 0,    9, 2};
    rows[7]  = '{K_NORM,    1, 0, 0,    9, 2};
    rows[8]  = '{K_NORM,    1, 0, 0,    9, 3};
    rows[9]  = '{K_DROP,    1, 0, 0,    9, 4};
    rows[10] = '{K_NORM,    0, 1, 6'h20, 8, 4};
    rows[11] = '{K_NORM,    0, 0, 0,    9, 4};
    rows[12] = '{K_NORM,    1, 0, 0,    9, 4};
    rows[13] = '{K_TIMEOUT, 0, 0, 0,    9, 5};
    rows[14] = '{K_NORM,    0, 0, 0,    9, 5};
    rows[15] = '{K_NORM,    0, 0, 0,    9, 5};
    rows[16] = '{K_NORM,    1, 0, 0,    9, 5};
    rows[17] = '{K_NORM,    1, 0, 0,    9, 6};
    rows[18] = '{K_RESET,   0, 0, 0,    0, 0};
    rows[19] = '{K_NORM,    0, 0, 0,    9, 0};
    rows[20] = '{K_NORM,    1, 0, 0,    9, 0};
    rows[21] = '{K_NORM,    1, 0, 0,    9, 1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");

    for (int r = 0; r < NROWS; r++) begin
      ferr0 = n_ferr;
      send_frame(rows[r].kind);
      @(negedge clk);
      chk($sformatf("row%0d_locked", r), locked, rows[r].locked);
      chk($sformatf("row%0d_frameErr_pulses", r), n_ferr - ferr0, rows[r].ferr);
      chk($sformatf("row%0d_errFlags", r), errFlags, rows[r].flags);
      chk($sformatf("row%0d_measV", r), measVTotal, rows[r].measv);
      chk($sformatf("row%0d_frames", r), frames, rows[r].frames);
      chk($sformatf("row%0d_measH", r), measHTotal, HT);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
